// File: rtl/uart_mmio_tx.sv
// uart_mmio_tx: memory-mapped UART transmitter with a TX FIFO.
//
// Register block at BASE_ADDR (16-byte window):
//   0x0 TXDATA   store pushes byte into FIFO, load returns 0
//   0x4 STATUS   {8'b0, count[7:0], 7'b0, overflow, 4'b0, parity_en, busy, empty, full}
//                store with bit8=1 clears overflow
//   0x8 BAUD_DIV 16-bit, bit period = BAUD_DIV+1 clk cycles
//   0xC reserved
//
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   m_addr        core byte address
//   m_wr_dat      core store data
//   rd_en, wr_en  single-cycle load/store strobes
//   m_rd_dat      load data (combinational)
//   tx            serial output, idle high
//
// Build option: define UART_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a byte
// START  | start bit (tx=0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit (tx=1), then next byte or IDLE

module uart_mmio_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h90000000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wr_dat,
  input  logic        rd_en,
  input  logic        wr_en,
  output logic [31:0] m_rd_dat,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic PARITY_EN = 1'b1;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic PARITY_EN = 1'b0;
`endif

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   baud_div;
  logic [15:0]   baud_cnt;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_idx;

  logic       sel;
  logic [3:0] off;
  logic       push;
  logic       clr_ovf;
  logic       wr_baud;
  logic       full;
  logic       empty;
  logic       bit_done;
  logic       bypass;
  logic       take_idle;
  logic       take_stop;
  logic       pop;
  logic       fifo_wr;

  assign sel      = (m_addr[31:4] == BASE_ADDR[31:4]);
  assign off      = m_addr[3:0];
  assign push     = wr_en & sel & (off == 4'h0);
  assign clr_ovf  = wr_en & sel & (off == 4'h4) & m_wr_dat[8];
  assign wr_baud  = wr_en & sel & (off == 4'h8);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign bit_done = (baud_cnt == '0);

  // A push into an empty FIFO while idle goes straight to the shift register
  // so the start bit begins on the very next cycle.
  assign bypass    = (state == S_IDLE) & empty & push;
  assign take_idle = (state == S_IDLE) & (!empty | push);
  assign take_stop = (state == S_STOP) & bit_done & !empty;
  assign pop       = ((state == S_IDLE) & !empty) | take_stop;
  // A push to a full FIFO still fits when a pop frees a slot on the same edge.
  assign fifo_wr   = push & !bypass & (!full | pop);

  always_comb begin
    m_rd_dat = '0;
    if (rd_en && sel) begin
      case (off)
        4'h4: begin
          m_rd_dat[0]     = full;
          m_rd_dat[1]     = empty;
          m_rd_dat[2]     = (state != S_IDLE);
          m_rd_dat[3]     = PARITY_EN;
          m_rd_dat[8]     = overflow;
          m_rd_dat[23:16] = 8'(count);
        end
        4'h8:    m_rd_dat[15:0] = baud_div;
        default: m_rd_dat = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[tail] <= m_wr_dat[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      baud_div <= DEFAULT_DIV;
    end else begin
      if (fifo_wr) tail <= tail + 1'b1;
      if (pop)     head <= head + 1'b1;
      case ({fifo_wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_ovf)         overflow <= 1'b0;
      if (wr_baud) baud_div <= m_wr_dat[15:0];
    end
  end

  // Data bits are indexed rather than shifted so the parity bit can be
  // computed from the whole byte at the end of the data phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tx        <= 1'b1;
      shift_reg <= '0;
      bit_idx   <= '0;
      baud_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (take_idle) begin
            shift_reg <= empty ? m_wr_dat[7:0] : mem[head];
            state     <= S_START;
            tx        <= 1'b0;
            baud_cnt  <= baud_div;
          end
        end
        S_START: begin
          if (bit_done) begin
            state    <= S_DATA;
            tx       <= shift_reg[0];
            bit_idx  <= '0;
            baud_cnt <= baud_div;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud_cnt <= baud_div;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= ^shift_reg;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            state    <= S_STOP;
            tx       <= 1'b1;
            baud_cnt <= baud_div;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_done) begin
            if (take_stop) begin
              shift_reg <= mem[head];
              state     <= S_START;
              tx        <= 1'b0;
              baud_cnt  <= baud_div;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Testbench for uart_mmio_tx: register access, frame timing, FIFO fill and
// overflow, back-to-back frames and reset abort. Transmitted frames are
// decoded by a line monitor and compared against a byte scoreboard.

module tb_uart_mmio_tx;

  localparam logic [31:0] BASE = 32'h90000000;
`ifdef UART_TX_PARITY_EN
  localparam int   NB  = 11;
  localparam logic PAR = 1'b1;
`else
  localparam int   NB  = 10;
  localparam logic PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wr_dat = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] m_rd_dat;
  logic        tx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] sb_q[$];
  int  mon_bp = 4;
  bit  mon_en = 1'b0;
  int  frame_starts = 0;
  int  contig = 0;
  int  last_end = -1;

  uart_mmio_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd433)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m_addr  (m_addr),
    .m_wr_dat(m_wr_dat),
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .m_rd_dat(m_rd_dat),
    .tx      (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NB-1:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  // Line monitor: decodes each frame at mid-bit and checks it against the scoreboard.
  initial begin : monitor
    logic [NB-1:0] bits;
    logic [NB-1:0] ef;
    logic [7:0]    exp_b;
    int            st;
    bit            aborted;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        st = cyc;
        aborted = 1'b0;
        frame_starts++;
        if (st == last_end) contig++;
        bits = '0;
        for (int k = 1; k < NB * mon_bp; k++) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
          if (k % mon_bp == mon_bp / 2) bits[k / mon_bp] = tx;
        end
        last_end = st + NB * mon_bp;
        if (!aborted) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got frame %b, expected no frame", bits);
          end else begin
            exp_b = sb_q.pop_front();
            ef = make_frame(exp_b);
            if (bits !== ef) begin
              errors++;
              $display("FAIL frame_data: got %b, expected %b (byte %h)", bits, ef, exp_b);
            end
          end
        end
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    m_addr = a; m_wr_dat = d; wr_en = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    m_addr = a; rd_en = 1'b1;
    #1 d = m_rd_dat;
    rd_en = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    @(negedge clk);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, expected 1", tx); end
    reset = 1'b0;
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h, expected 00000002", d); end
    bus_read(BASE + 32'h8, d);
    checks++;
    if (d !== 32'd433) begin errors++; $display("FAIL reset_baud: got %h, expected %h", d, 32'd433); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    bus_write(BASE + 32'h8, 32'hABCD_0010);
    bus_read(BASE + 32'h8, d);
    checks++;
    if (d !== 32'h10) begin errors++; $display("FAIL baud_rw: got %h, expected 00000010", d); end
    bus_read(BASE + 32'h10, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL out_of_range_read: got %h, expected 0", d); end
    bus_write(BASE + 32'h18, 32'h0000_FFFF);
    bus_write(BASE + 32'h10, 32'h0000_0055);
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h8, d);
    checks++;
    if (d !== 32'h10) begin errors++; $display("FAIL foreign_write: baud got %h, expected 00000010", d); end
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL foreign_write_status: got %h, expected 00000002", d); end
    bus_read(BASE + 32'hC, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h, expected 0", d); end
    bus_read(BASE, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h, expected 0", d); end
    // simultaneous load and store: load sees the pre-store value
    @(negedge clk);
    m_addr = BASE + 32'h8; m_wr_dat = 32'h3; wr_en = 1'b1; rd_en = 1'b1;
    #1 d = m_rd_dat;
    checks++;
    if (d !== 32'h10) begin errors++; $display("FAIL rdwr_same_cycle: got %h, expected 00000010", d); end
    @(posedge clk);
    #1 wr_en = 1'b0; rd_en = 1'b0;
    bus_read(BASE + 32'h8, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL rdwr_store: got %h, expected 00000003", d); end
  endtask

  task automatic test_single_frame();
    logic [NB-1:0] fr;
    logic [31:0]   d;
    int            bad;
    fr = make_frame(8'hA5);
    sb_q.push_back(8'hA5);
    bus_write(BASE, 32'h0000_00A5);
    bad = 0;
    for (int i = 0; i < NB * 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== fr[i / 4]) begin
        errors++;
        if (bad < 4) $display("FAIL frame_timing: cycle %0d got tx=%b, expected %b", i, tx, fr[i / 4]);
        bad++;
      end
    end
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL post_frame_status: got %h, expected 00000002", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  b;
    int c1, base_fs, base_ct, g;
    base_fs = frame_starts;
    base_ct = contig;
    c1 = 0;
    for (int i = 0; i < 9; i++) begin
      b = 8'(8'h31 + i * 23);
      sb_q.push_back(b);
      bus_write(BASE, {24'h0, b});
      if (i == 0) c1 = cyc;
    end
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h0008_0005) begin errors++; $display("FAIL fill_status: got %h, expected 00080005", d); end
    bus_write(BASE, 32'h0000_00EE);
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h0008_0105) begin errors++; $display("FAIL overflow_status: got %h, expected 00080105", d); end
    bus_write(BASE + 32'h4, 32'h0000_0100);
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h0008_0005) begin errors++; $display("FAIL overflow_clear: got %h, expected 00080005", d); end
    // push on the last stop-bit cycle of frame 1: pop frees a slot on the same edge
    wait_cyc(c1 + NB * 4 - 1);
    checks++;
    if (cyc != c1 + NB * 4 - 1) begin errors++; $display("FAIL push_pop_timing: at cycle %0d, expected %0d", cyc, c1 + NB * 4 - 1); end
    sb_q.push_back(8'hC3);
    m_addr = BASE; m_wr_dat = 32'h0000_00C3; wr_en = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h0008_0005) begin errors++; $display("FAIL push_pop_full: got %h, expected 00080005", d); end
    for (int n = 2; n <= 10; n++) begin
      g = 0;
      while (frame_starts < base_fs + n && g < 200) begin @(negedge clk); g++; end
      bus_read(BASE + 32'h4, d);
      checks++;
      if (g >= 200 || d[23:16] !== 8'(10 - n)) begin
        errors++;
        $display("FAIL count_decrement: frame %0d count got %0d, expected %0d (wait %0d)", n, d[23:16], 10 - n, g);
      end
    end
    g = 0;
    while (sb_q.size() != 0 && g < 2000) begin @(negedge clk); g++; end
    repeat (10) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL drain: %0d bytes not sent, expected 0", sb_q.size()); end
    checks++;
    if (contig - base_ct != 9) begin errors++; $display("FAIL contiguous: got %0d joins, expected 9", contig - base_ct); end
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL drained_status: got %h, expected 00000002", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int c1, lows;
    bus_write(BASE, 32'h0000_0000);
    c1 = cyc;
    bus_write(BASE, 32'h0000_0055);
    wait_cyc(c1 + 15);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL pre_reset_tx: got %b, expected 0", tx); end
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b, expected 1", tx); end
    bus_write(BASE, 32'h0000_0077);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL no_resume: tx low %0d cycles, expected 0", lows); end
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL reset_abort_status: got %h, expected 00000002", d); end
    bus_read(BASE + 32'h8, d);
    checks++;
    if (d !== 32'd433) begin errors++; $display("FAIL reset_abort_baud: got %h, expected %h", d, 32'd433); end
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    mon_bp = 4;
    test_regs();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
